// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory-access stage: decoded ops, access sizes, strobes
// and the transaction FSM states, plus op classification helpers.
package mem_access_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LD  = 4'd1,
        OP_LB  = 4'd2,
        OP_LH  = 4'd3,
        OP_LW  = 4'd4,
        OP_LBU = 4'd5,
        OP_LHU = 4'd6,
        OP_LWU = 4'd7,
        OP_SD  = 4'd8,
        OP_SB  = 4'd9,
        OP_SH  = 4'd10,
        OP_SW  = 4'd11,
        OP_ALU = 4'd12
    } op_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    function automatic logic is_mem_op(input op_t op);
        case (op)
            OP_LD, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU,
            OP_SD, OP_SB, OP_SH, OP_SW: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input op_t op);
        case (op)
            OP_LD, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_align.sv
// Combinational lane logic: access size, store strobe/data lane shift,
// misalignment detection and load-data extraction with extension.
module mem_align
    import mem_access_ctrl_pkg::*;
(
    input  op_t         op,
    input  logic [2:0]  off,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output msize_t      size,
    output strobe_t     strobe,
    output logic [63:0] wdata_lane,
    output logic        misalign,
    output logic [63:0] rdata_ext
);

    strobe_t     mask_s;
    logic [63:0] wmask_s;
    logic [63:0] rsh_s;
    logic        store_s;

    // Access size, byte mask and alignment check derived from the op.
    always_comb begin
        size     = MSIZE1;
        mask_s   = 8'h01;
        misalign = 1'b0;
        case (op)
            OP_LD, OP_SD:          size = MSIZE8;
            OP_LW, OP_LWU, OP_SW:  size = MSIZE4;
            OP_LH, OP_LHU, OP_SH:  size = MSIZE2;
            default:               size = MSIZE1;
        endcase
        case (size)
            MSIZE8: begin mask_s = 8'hFF; misalign = (off != 3'd0);        end
            MSIZE4: begin mask_s = 8'h0F; misalign = (off[1:0] != 2'd0);   end
            MSIZE2: begin mask_s = 8'h03; misalign = off[0];               end
            default: begin mask_s = 8'h01; misalign = 1'b0;                end
        endcase
    end

    // Store lane placement; loads and non-memory ops drive no strobes.
    always_comb begin
        wmask_s = 64'd0;
        for (int i = 0; i < 8; i++) begin
            wmask_s[8*i +: 8] = {8{mask_s[i]}};
        end
        store_s = is_mem_op(op) & ~is_load(op);
        if (store_s) begin
            strobe     = mask_s << off;
            wdata_lane = (wdata & wmask_s) << {off, 3'b000};
        end else begin
            strobe     = 8'h00;
            wdata_lane = 64'd0;
        end
    end

    // Load extraction: bring the addressed lane down, then extend to 64 bits.
    always_comb begin
        rsh_s = rdata >> {off, 3'b000};
        case (op)
            OP_LD:   rdata_ext = rsh_s;
            OP_LB:   rdata_ext = {{56{rsh_s[7]}},  rsh_s[7:0]};
            OP_LH:   rdata_ext = {{48{rsh_s[15]}}, rsh_s[15:0]};
            OP_LW:   rdata_ext = {{32{rsh_s[31]}}, rsh_s[31:0]};
            OP_LBU:  rdata_ext = {56'd0, rsh_s[7:0]};
            OP_LHU:  rdata_ext = {48'd0, rsh_s[15:0]};
            OP_LWU:  rdata_ext = {32'd0, rsh_s[31:0]};
            default: rdata_ext = 64'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage bus sequencer: issues one dbus request per load/store, stalls
// the pipeline while it is outstanding and presents the result for one cycle.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  op_t               in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              flush,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_mdata,
    output logic              out_misalign
);

    mem_state_t        state_q, state_d;
    op_t               op_q, op_d;
    logic              drop_q, drop_d;
    logic              dreq_valid_q, dreq_valid_d;
    logic [ADDR_W-1:0] dreq_addr_q, dreq_addr_d;
    msize_t            dreq_size_q, dreq_size_d;
    strobe_t           dreq_strobe_q, dreq_strobe_d;
    logic [DATA_W-1:0] dreq_data_q, dreq_data_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_mdata_q, out_mdata_d;
    logic              out_misalign_q, out_misalign_d;

    logic              accept_s;
    op_t               align_op_s;
    logic [2:0]        align_off_s;
    msize_t            size_s;
    strobe_t           strobe_s;
    logic [DATA_W-1:0] wlane_s;
    logic [DATA_W-1:0] rext_s;
    logic              misalign_s;

    // In IDLE the aligner looks at the incoming op; afterwards at the latched request.
    assign align_op_s  = (state_q == IDLE) ? in_op : op_q;
    assign align_off_s = (state_q == IDLE) ? in_addr[2:0] : dreq_addr_q[2:0];
    assign accept_s    = in_valid & is_mem_op(in_op) & ~flush;

    mem_align u_align (
        .op         (align_op_s),
        .off        (align_off_s),
        .wdata      (in_wdata),
        .rdata      (dresp_data),
        .size       (size_s),
        .strobe     (strobe_s),
        .wdata_lane (wlane_s),
        .misalign   (misalign_s),
        .rdata_ext  (rext_s)
    );

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        drop_d         = drop_q;
        dreq_valid_d   = dreq_valid_q;
        dreq_addr_d    = dreq_addr_q;
        dreq_size_d    = dreq_size_q;
        dreq_strobe_d  = dreq_strobe_q;
        dreq_data_d    = dreq_data_q;
        out_valid_d    = 1'b0;
        out_mdata_d    = out_mdata_q;
        out_misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (accept_s) begin
                    op_d = in_op;
                    if (misalign_s) begin
                        state_d        = RESP;
                        out_valid_d    = 1'b1;
                        out_misalign_d = 1'b1;
                        out_mdata_d    = {DATA_W{1'b0}};
                    end else begin
                        state_d       = BUSY;
                        dreq_valid_d  = 1'b1;
                        dreq_addr_d   = in_addr;
                        dreq_size_d   = size_s;
                        dreq_strobe_d = strobe_s;
                        dreq_data_d   = wlane_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (flush) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                // The bus transaction always runs to completion; a flush only drops its result.
                if (dresp_data_ok) begin
                    dreq_valid_d = 1'b0;
                    if (drop_q | flush) begin
                        state_d = IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        state_d     = RESP;
                        out_valid_d = 1'b1;
                        out_mdata_d = is_load(op_q) ? rext_s : {DATA_W{1'b0}};
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            RESP: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
            default: begin
                state_d      = IDLE;
                dreq_valid_d = 1'b0;
                drop_d       = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            op_q           <= OP_NOP;
            drop_q         <= 1'b0;
            dreq_valid_q   <= 1'b0;
            dreq_addr_q    <= {ADDR_W{1'b0}};
            dreq_size_q    <= MSIZE1;
            dreq_strobe_q  <= 8'h00;
            dreq_data_q    <= {DATA_W{1'b0}};
            out_valid_q    <= 1'b0;
            out_mdata_q    <= {DATA_W{1'b0}};
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            drop_q         <= drop_d;
            dreq_valid_q   <= dreq_valid_d;
            dreq_addr_q    <= dreq_addr_d;
            dreq_size_q    <= dreq_size_d;
            dreq_strobe_q  <= dreq_strobe_d;
            dreq_data_q    <= dreq_data_d;
            out_valid_q    <= out_valid_d;
            out_mdata_q    <= out_mdata_d;
            out_misalign_q <= out_misalign_d;
        end
    end

    assign dreq_valid   = dreq_valid_q;
    assign dreq_addr    = dreq_addr_q;
    assign dreq_size    = dreq_size_q;
    assign dreq_strobe  = dreq_strobe_q;
    assign dreq_data    = dreq_data_q;
    assign out_valid    = out_valid_q & ~flush;
    assign out_mdata    = out_mdata_q;
    assign out_misalign = out_misalign_q;
    assign stall        = (accept_s & (state_q == IDLE)) | (state_q == BUSY);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// accesses compared against a byte-level reference model.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    op_t         in_op = OP_NOP;
    logic [63:0] in_addr = 64'd0;
    logic [63:0] in_wdata = 64'd0;
    logic        flush = 1'b0;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok = 1'b0;
    logic [63:0] dresp_data = 64'd0;
    logic        stall;
    logic        out_valid;
    logic [63:0] out_mdata;
    logic        out_misalign;

    int n_cmp = 0;
    int n_fail = 0;

    // Observations gathered by run_access.
    int          obs_req, obs_out, obs_out_k;
    logic [63:0] obs_addr, obs_data, obs_mdata;
    logic [2:0]  obs_size;
    logic [7:0]  obs_strobe;
    logic        obs_mis, obs_stable, obs_stall_ok, obs_late, obs_acc_stall;

    op_t mem_ops [11] = '{OP_LD, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU,
                          OP_SD, OP_SB, OP_SH, OP_SW};

    mem_access_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
        .in_addr(in_addr), .in_wdata(in_wdata), .flush(flush),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .stall(stall), .out_valid(out_valid), .out_mdata(out_mdata),
        .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int nbytes(input op_t op);
        case (op)
            OP_LD, OP_SD:         return 8;
            OP_LW, OP_LWU, OP_SW: return 4;
            OP_LH, OP_LHU, OP_SH: return 2;
            default:              return 1;
        endcase
    endfunction

    function automatic bit m_load(input op_t op);
        return (op == OP_LD || op == OP_LB || op == OP_LH || op == OP_LW ||
                op == OP_LBU || op == OP_LHU || op == OP_LWU);
    endfunction

    function automatic bit m_signed(input op_t op);
        return (op == OP_LB || op == OP_LH || op == OP_LW);
    endfunction

    function automatic bit m_mis(input op_t op, input logic [63:0] a);
        return (int'(a[2:0]) % nbytes(op)) != 0;
    endfunction

    function automatic logic [2:0] m_size(input op_t op);
        int n = nbytes(op);
        return (n == 8) ? 3'd3 : (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
    endfunction

    function automatic logic [7:0] m_strobe(input op_t op, input logic [63:0] a);
        logic [7:0] s = 8'h00;
        int off = int'(a[2:0]);
        if (!m_load(op))
            for (int i = 0; i < 8; i++) s[i] = (i >= off) && (i < off + nbytes(op));
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(input op_t op, input logic [63:0] a, input logic [63:0] w);
        logic [63:0] d = 64'd0;
        int off = int'(a[2:0]);
        if (!m_load(op))
            for (int i = 0; i < nbytes(op); i++) d[8*(off+i) +: 8] = w[8*i +: 8];
        return d;
    endfunction

    function automatic logic [63:0] m_ldval(input op_t op, input logic [63:0] a, input logic [63:0] r);
        logic [63:0] v = 64'd0;
        int off = int'(a[2:0]);
        int n = nbytes(op);
        for (int i = 0; i < n; i++) v[8*i +: 8] = r[8*(off+i) +: 8];
        if (m_signed(op) && v[8*n-1])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // Drive one access, play the bus for wait_n idle cycles, and record what the DUT did.
    task automatic run_access(input op_t op, input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] rdata, input int wait_n, input int flush_k);
        logic ok_seen = 1'b0;
        obs_req = 0; obs_out = 0; obs_out_k = -1; obs_mdata = 64'd0; obs_mis = 1'b0;
        obs_stable = 1'b1; obs_stall_ok = 1'b1; obs_late = 1'b0;
        obs_addr = 64'd0; obs_data = 64'd0; obs_size = 3'd0; obs_strobe = 8'd0;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata;
        #1 obs_acc_stall = stall;
        for (int k = 1; k <= wait_n + 6; k++) begin
            @(negedge clk);
            in_valid = 1'b0; dresp_data_ok = 1'b0; flush = 1'b0;
            dresp_data = {$urandom(), $urandom()};
            #1;
            if (dreq_valid) begin
                if (ok_seen) obs_late = 1'b1;
                obs_req++;
                if (obs_req == 1) begin
                    obs_addr = dreq_addr; obs_size = dreq_size;
                    obs_strobe = dreq_strobe; obs_data = dreq_data;
                end else if (dreq_addr !== obs_addr || dreq_size !== obs_size ||
                             dreq_strobe !== obs_strobe || dreq_data !== obs_data) begin
                    obs_stable = 1'b0;
                end
                if (stall !== 1'b1) obs_stall_ok = 1'b0;
                if (obs_req == wait_n + 1) begin
                    dresp_data_ok = 1'b1; dresp_data = rdata; ok_seen = 1'b1;
                end
            end
            if (out_valid) begin
                obs_out++; obs_out_k = k; obs_mdata = out_mdata; obs_mis = out_misalign;
                if (stall !== 1'b0) obs_stall_ok = 1'b0;
            end
            if (k == flush_k) flush = 1'b1;
        end
        dresp_data_ok = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if ({dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, out_valid, out_mdata, out_misalign, stall} !== '0) begin
            n_fail++; $display("FAIL reset_state: outputs=%h required all zero",
                {dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, out_valid, out_mdata, out_misalign});
        end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_lw;
        run_access(OP_LW, 64'h1004, 64'd0, 64'h8000_0001_1234_5678, 1, -1);
        n_cmp++; if (obs_size !== 3'd2 || obs_strobe !== 8'h00) begin n_fail++;
            $display("FAIL lw_req: size=%0d strobe=%h required 2/00", obs_size, obs_strobe); end
        n_cmp++; if (obs_mdata !== 64'hFFFF_FFFF_8000_0001) begin n_fail++;
            $display("FAIL lw_data: got %h required ffffffff80000001", obs_mdata); end
        n_cmp++; if (obs_out !== 1 || obs_out_k !== 3 || !obs_stall_ok || !obs_acc_stall) begin n_fail++;
            $display("FAIL lw_pulse: pulses=%0d at=%0d stall_ok=%b required 1/3/1", obs_out, obs_out_k, obs_stall_ok); end
    endtask

    task automatic test_sb;
        run_access(OP_SB, 64'h2003, 64'h0000_0000_0000_00AB, 64'd0, 0, -1);
        n_cmp++; if (obs_strobe !== 8'h08 || obs_data[31:24] !== 8'hAB || obs_size !== 3'd0) begin n_fail++;
            $display("FAIL sb_req: strobe=%h data=%h size=%0d required 08/ab@[31:24]/0", obs_strobe, obs_data, obs_size); end
        n_cmp++; if (obs_out !== 1 || obs_out_k !== 2 || obs_mdata !== 64'd0 || obs_addr !== 64'h2003) begin n_fail++;
            $display("FAIL sb_done: pulses=%0d at=%0d mdata=%h addr=%h required 1/2/0/2003", obs_out, obs_out_k, obs_mdata, obs_addr); end
    endtask

    task automatic test_misalign;
        run_access(OP_LH, 64'h3001, 64'd0, 64'd0, 0, -1);
        n_cmp++; if (obs_req !== 0 || obs_out !== 1 || obs_out_k !== 1 || obs_mis !== 1'b1) begin n_fail++;
            $display("FAIL lh_misalign: req=%0d pulses=%0d at=%0d mis=%b required 0/1/1/1", obs_req, obs_out, obs_out_k, obs_mis); end
        run_access(OP_LHU, 64'h3002, 64'd0, 64'h0000_0000_F00D_0000, 0, -1);
        n_cmp++; if (obs_mdata !== 64'h0000_0000_0000_F00D || obs_mis !== 1'b0 || obs_out_k !== 2) begin n_fail++;
            $display("FAIL lhu_data: got %h mis=%b at=%0d required f00d/0/2", obs_mdata, obs_mis, obs_out_k); end
    endtask

    task automatic test_ld_hold;
        run_access(OP_LD, 64'h4008, 64'd0, 64'h0123_4567_89AB_CDEF, 5, -1);
        n_cmp++; if (obs_req !== 6 || !obs_stable || !obs_stall_ok || obs_late) begin n_fail++;
            $display("FAIL ld_hold: req=%0d stable=%b stall_ok=%b late=%b required 6/1/1/0", obs_req, obs_stable, obs_stall_ok, obs_late); end
        n_cmp++; if (obs_mdata !== 64'h0123_4567_89AB_CDEF || obs_out_k !== 7) begin n_fail++;
            $display("FAIL ld_data: got %h at=%0d required 0123456789abcdef/7", obs_mdata, obs_out_k); end
    endtask

    task automatic test_flush;
        run_access(OP_LW, 64'h5000, 64'd0, 64'h1111_2222_3333_4444, 3, 2);
        n_cmp++; if (obs_req !== 4 || obs_out !== 0) begin n_fail++;
            $display("FAIL flush_busy: req=%0d pulses=%0d required 4/0", obs_req, obs_out); end
        run_access(OP_LBU, 64'h5006, 64'd0, 64'h00C3_0000_0000_0000, 0, -1);
        n_cmp++; if (obs_out !== 1 || obs_mdata !== 64'h0000_0000_0000_00C3) begin n_fail++;
            $display("FAIL flush_next: pulses=%0d mdata=%h required 1/c3", obs_out, obs_mdata); end
        // Flush and non-memory ops in IDLE must not start anything.
        @(negedge clk); in_valid = 1'b1; in_op = OP_LD; in_addr = 64'h6000; flush = 1'b1;
        #1 n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall: got %b required 0", stall); end
        @(negedge clk); flush = 1'b0; in_op = OP_ALU;
        #1 n_cmp++; if (stall !== 1'b0 || dreq_valid !== 1'b0) begin n_fail++;
            $display("FAIL nonmem_ignored: stall=%b dreq_valid=%b required 0/0", stall, dreq_valid); end
        @(negedge clk); in_valid = 1'b0;
        n_cmp++; if (dreq_valid !== 1'b0 || out_valid !== 1'b0) begin n_fail++;
            $display("FAIL nonmem_idle: dreq_valid=%b out_valid=%b required 0/0", dreq_valid, out_valid); end
    endtask

    task automatic test_reset_mid_busy;
        @(negedge clk); in_valid = 1'b1; in_op = OP_LD; in_addr = 64'h7040;
        @(negedge clk); in_valid = 1'b0;
        n_cmp++; if (dreq_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: dreq_valid=%b required 1", dreq_valid); end
        #2 reset = 1'b0;
        #1 n_cmp++;
        if ({dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, out_valid, out_mdata, out_misalign, stall} !== '0) begin
            n_fail++; $display("FAIL rst_async: dreq_valid=%b addr=%h mdata=%h stall=%b required all zero",
                dreq_valid, dreq_addr, out_mdata, stall);
        end
        @(negedge clk); reset = 1'b1;
        run_access(OP_SD, 64'h0, 64'hDEAD_BEEF_0BAD_F00D, 64'd0, 0, -1);
        n_cmp++; if (obs_strobe !== 8'hFF || obs_data !== 64'hDEAD_BEEF_0BAD_F00D || obs_out !== 1) begin n_fail++;
            $display("FAIL rst_sd: strobe=%h data=%h pulses=%0d required ff/deadbeef0badf00d/1", obs_strobe, obs_data, obs_out); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            op_t op = mem_ops[$urandom_range(0, 10)];
            logic [63:0] a = {$urandom(), $urandom()};
            logic [63:0] w = {$urandom(), $urandom()};
            logic [63:0] r = {$urandom(), $urandom()};
            int wn = $urandom_range(0, 3);
            bit mis;
            if ($urandom_range(0, 1) == 0) a[2:0] = 3'd0;
            mis = m_mis(op, a);
            run_access(op, a, w, r, wn, -1);
            n_cmp++; if (obs_mis !== mis || obs_out !== 1 || obs_out_k !== (mis ? 1 : wn + 2)) begin n_fail++;
                $display("FAIL rnd_done[%0d]: mis=%b pulses=%0d at=%0d required %b/1/%0d", it, obs_mis, obs_out, obs_out_k, mis, mis ? 1 : wn + 2); end
            n_cmp++; if (obs_req !== (mis ? 0 : wn + 1) || !obs_stable || !obs_stall_ok || obs_late || !obs_acc_stall) begin n_fail++;
                $display("FAIL rnd_handshake[%0d]: req=%0d stable=%b stall_ok=%b late=%b", it, obs_req, obs_stable, obs_stall_ok, obs_late); end
            if (!mis) begin
                n_cmp++;
                if (obs_addr !== a || obs_size !== m_size(op) || obs_strobe !== m_strobe(op, a) || obs_data !== m_wdata(op, a, w)) begin
                    n_fail++; $display("FAIL rnd_req[%0d]: addr=%h size=%0d strobe=%h data=%h required %h/%0d/%h/%h", it,
                        obs_addr, obs_size, obs_strobe, obs_data, a, m_size(op), m_strobe(op, a), m_wdata(op, a, w));
                end
            end
            n_cmp++;
            if (obs_mdata !== ((m_load(op) && !mis) ? m_ldval(op, a, r) : 64'd0)) begin
                n_fail++; $display("FAIL rnd_mdata[%0d]: got %h required %h", it, obs_mdata,
                    (m_load(op) && !mis) ? m_ldval(op, a, r) : 64'd0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sb();
        test_misalign();
        test_ld_hold();
        test_flush();
        test_reset_mid_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences one load or store per instruction from the memory stage onto the data bus (dbus) using a request/response handshake.
- Holds the pipeline while a transaction is outstanding.
- Produces the aligned and sign/zero-extended load word, which feeds the memory stage's load-vs-ALU result select.
- Detects misaligned accesses without touching the bus, and drains in-flight transactions cleanly on flush.

Parameters:
- ADDR_W, 64, byte address width.
- DATA_W, 64, bus data width (8 byte lanes; only 64 is supported).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  memory stage holds a valid instruction.
- in_op  in  decoded op (control_t.op type)  LD/LB/LH/LW/LBU/LHU/LWU/SD/SB/SH/SW; any other op is a non-memory op.
- in_addr  in  ADDR_W  effective address.
- in_wdata  in  DATA_W  store source register value.
- flush  in  1  kill the current instruction.
- dreq_valid  out  1  bus request.
- dreq_addr  out  ADDR_W  request address.
- dreq_size  out  3  msize_t encoding: 0=1B, 1=2B, 2=4B, 3=8B.
- dreq_strobe  out  8  byte write enables; all zero for loads.
- dreq_data  out  DATA_W  lane-shifted store data.
- dresp_data_ok  in  1  bus completes the request this cycle.
- dresp_data  in  DATA_W  raw bus read data.
- stall  out  1  freeze upstream stages.
- out_valid  out  1  one-cycle completion pulse.
- out_mdata  out  DATA_W  extended load result.
- out_misalign  out  1  misaligned-access exception, qualified by out_valid.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, dreq_valid=0, dreq_addr/size/strobe/data=0, out_valid=0, out_mdata=0, out_misalign=0, drop=0.
- States:
  - IDLE.
  - BUSY: request outstanding.
  - RESP: registered result-presentation cycle.
- IDLE:
  - If in_valid is set, the op is a memory op and flush=0, latch op, addr and wdata.
  - Misaligned accesses (below) go to RESP with out_misalign=1 and never assert dreq_valid.
  - Otherwise go to BUSY.
  - Non-memory ops are ignored: stall=0, no state change.
- Misalignment rules:
  - LD/SD: addr[2:0]!=0.
  - LW/LWU/SW: addr[1:0]!=0.
  - LH/LHU/SH: addr[0]!=0.
  - Byte ops never misalign.
- BUSY:
  - dreq_valid=1 and all dreq_* fields are stable until the cycle in which dresp_data_ok=1.
  - On dresp_data_ok: register the extracted data into out_mdata, deassert dreq_valid the next cycle, and go to RESP. If drop=1, go to IDLE instead.
  - dresp_data_ok in the same cycle dreq_valid first rises is legal.
- RESP: out_valid=1 for exactly one cycle, then IDLE.
- stall: 1 when (in_valid and memory op and state==IDLE and flush=0) or state==BUSY; 0 in RESP, so the pipeline advances on the out_valid cycle.
- Minimum load latency is 3 cycles: accept (cycle 0) → BUSY/request (cycle 1, data_ok the same cycle) → out_valid (cycle 2).
- Store encoding:
  - dreq_strobe = size mask << addr[2:0].
  - dreq_data = in_wdata low bytes << (8*addr[2:0]).
  - dreq_addr is the full unmodified address.
- Load extraction:
  - Shift dresp_data right by 8*addr[2:0].
  - Truncate to the access size.
  - Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU; LD passes through.
- Flush:
  - In IDLE: the access is not accepted.
  - In BUSY: set drop. The bus transaction must still complete and is never withdrawn; on data_ok go to IDLE with no out_valid.
  - In RESP: suppress out_valid.
  - drop clears on entering IDLE.
- After completion, a new access may be accepted in the cycle after RESP. The same instruction is never re-issued, because upstream has advanced.
- stores: out_valid pulses with out_mdata=0.

Decomposition:
- pipes package gains:
  - msize_t (3-bit enum MSIZE1/2/4/8).
  - strobe_t (8-bit).
  - mem_state_t enum {IDLE, BUSY, RESP}.
  - function is_mem_op(op).
  - function is_load(op).
- One combinational sub-module, mem_align, covers size/strobe/wdata lane shift, misalignment check and load extraction. The FSM stays in mem_access_ctrl.

Test Plan:
- LW at 0x1004, dresp_data=0x8000_0001_1234_5678, data_ok one cycle after dreq_valid → dreq_size=2, strobe=0, out_mdata=0xFFFF_FFFF_8000_0001, out_valid single pulse, stall high until the pulse.
- SB at 0x2003, wdata=0xAB → dreq_strobe=0x08, dreq_data[31:24]=0xAB, dreq_size=0, out_valid one cycle after data_ok.
- LH at 0x3001 → no dreq_valid ever, out_valid=1 with out_misalign=1 on cycle 1; a subsequent LHU at 0x3002 with data 0x0000_0000_F00D_0000 → out_mdata=0xF00D.
- LD held in BUSY for 5 cycles of data_ok=0 → dreq_addr/size/strobe/data constant, stall=1 throughout; data_ok on cycle 6 → out_mdata=raw data.
- flush asserted during BUSY → dreq_valid stays until data_ok, no out_valid, next access accepted.
- reset asserted mid-BUSY → all outputs 0 asynchronously; after release, a new SD at 0x0 completes with strobe=0xFF.
